branch_predictor: RTL and testbench



---
 rtl/branch_predictor_pkg.sv | 17 +
 rtl/branch_predictor_sat_counter2.sv | 19 +
 rtl/branch_predictor.sv | 137 +++++++++++++
 tb/tb_branch_predictor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared widths, counter reset value and BTB entry layout
package branch_predictor_pkg;

    localparam int GHR_W = 8;
    localparam int BTB_IDX_W = 6;
    localparam int BTB_TAG_W = 30 - BTB_IDX_W;

    localparam logic [1:0] CTR_RESET = 2'b01;

    typedef struct packed {
        logic                 valid;
        logic                 uncond;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit saturating up/down counter next-value logic
module sat_counter2 (
    input  logic [1:0] cnt_in,
    input  logic       inc,
    output logic [1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (inc) begin
            if (cnt_in != 2'b11) begin
                cnt_out = cnt_in + 2'd1;
            end
        end else if (cnt_in != 2'b00) begin
            cnt_out = cnt_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - gshare direction predictor with direct-mapped BTB and event counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int GHR_W     = branch_predictor_pkg::GHR_W,
    parameter int BTB_IDX_W = branch_predictor_pkg::BTB_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_is_cond,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [GHR_W-1:0] ex_ghr,
    output logic [31:0]      num_cond_branches,
    output logic [31:0]      num_uncond_branches,
    output logic [31:0]      bp_correct
);

    localparam int BHT_N = 1 << GHR_W;
    localparam int BTB_N = 1 << BTB_IDX_W;

    logic [1:0]       bht_q [BHT_N];
    logic [1:0]       bht_d [BHT_N];
    logic             btb_valid_q [BTB_N];
    logic             btb_valid_d [BTB_N];
    btb_entry_t       btb_q [BTB_N];
    btb_entry_t       btb_d [BTB_N];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [31:0]      num_cond_q, num_cond_d;
    logic [31:0]      num_uncond_q, num_uncond_d;
    logic [31:0]      bp_correct_q, bp_correct_d;

    logic [GHR_W-1:0]     rd_bht_idx;
    logic [BTB_IDX_W-1:0] rd_btb_idx;
    btb_entry_t           rd_entry;
    logic                 btb_hit;

    logic [GHR_W-1:0]     upd_bht_idx;
    logic [BTB_IDX_W-1:0] upd_btb_idx;
    logic [1:0]           bht_old;
    logic [1:0]           bht_new;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    // Valid lives in its own reset array; the stored valid bit is X until first write.
    always_comb begin
        rd_bht_idx  = if_pc[GHR_W+1:2] ^ ghr_q;
        rd_btb_idx  = if_pc[BTB_IDX_W+1:2];
        rd_entry    = btb_q[rd_btb_idx];
        btb_hit     = btb_valid_q[rd_btb_idx] && rd_entry.valid
                      && (rd_entry.tag == if_pc[31:BTB_IDX_W+2]);
        pred_taken  = btb_hit && (rd_entry.uncond || bht_q[rd_bht_idx][1]);
        pred_target = pred_taken ? rd_entry.target : (if_pc + 32'd4);
        pred_ghr    = ghr_q;
    end

    assign upd_bht_idx = ex_pc[GHR_W+1:2] ^ ex_ghr;
    assign upd_btb_idx = ex_pc[BTB_IDX_W+1:2];
    assign bht_old     = bht_q[upd_bht_idx];

    sat_counter2 u_bht_ctr (
        .cnt_in  (bht_old),
        .inc     (ex_taken),
        .cnt_out (bht_new)
    );

    always_comb begin
        bht_d        = bht_q;
        btb_valid_d  = btb_valid_q;
        btb_d        = btb_q;
        ghr_d        = ghr_q;
        num_cond_d   = num_cond_q;
        num_uncond_d = num_uncond_q;
        bp_correct_d = bp_correct_q;
        if (ex_valid) begin
            if (ex_is_cond) begin
                bht_d[upd_bht_idx] = bht_new;
                ghr_d              = {ghr_q[GHR_W-2:0], ex_taken};
                num_cond_d         = num_cond_q + 32'd1;
                if (ex_pred_taken == ex_taken) begin
                    bp_correct_d = bp_correct_q + 32'd1;
                end
            end else begin
                num_uncond_d = num_uncond_q + 32'd1;
            end
            if (ex_taken) begin
                btb_valid_d[upd_btb_idx] = 1'b1;
                btb_d[upd_btb_idx]       = '{valid:  1'b1,
                                             uncond: !ex_is_cond,
                                             tag:    ex_pc[31:BTB_IDX_W+2],
                                             target: ex_target};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= CTR_RESET;
            end
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
            ghr_q        <= '0;
            num_cond_q   <= '0;
            num_uncond_q <= '0;
            bp_correct_q <= '0;
        end else begin
            bht_q        <= bht_d;
            btb_valid_q  <= btb_valid_d;
            ghr_q        <= ghr_d;
            num_cond_q   <= num_cond_d;
            num_uncond_q <= num_uncond_d;
            bp_correct_q <= bp_correct_d;
        end
    end

    // Tag/target payload is not reset; an invalid slot is never consulted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_q <= btb_d;
        end
    end

    assign num_cond_branches   = num_cond_q;
    assign num_uncond_branches = num_uncond_q;
    assign bp_correct          = bp_correct_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_is_cond;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [7:0]  ex_ghr;
    logic [31:0] num_cond_branches;
    logic [31:0] num_uncond_branches;
    logic [31:0] bp_correct;

    branch_predictor dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_pc               (if_pc),
        .pred_taken          (pred_taken),
        .pred_target         (pred_target),
        .pred_ghr            (pred_ghr),
        .ex_valid            (ex_valid),
        .ex_pc               (ex_pc),
        .ex_target           (ex_target),
        .ex_is_cond          (ex_is_cond),
        .ex_taken            (ex_taken),
        .ex_pred_taken       (ex_pred_taken),
        .ex_ghr              (ex_ghr),
        .num_cond_branches   (num_cond_branches),
        .num_uncond_branches (num_uncond_branches),
        .bp_correct          (bp_correct)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_ghr;
    logic [31:0] exp_cond;
    logic [31:0] exp_uncond;
    logic [31:0] exp_correct;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_vec_t;

    typedef struct {
        logic       taken;
        logic [1:0] ctr;
    } ctr_vec_t;

    pred_vec_t pred_tbl [5];
    ctr_vec_t  ctr_tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc,
                              input logic taken, input logic [31:0] target);
        if_pc = pc;
        #1;
        chk({name, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, taken});
        chk({name, ".pred_target"}, pred_target, target);
    endtask

    task automatic check_state(input string name);
        chk({name, ".pred_ghr"}, {24'd0, pred_ghr}, {24'd0, exp_ghr});
        chk({name, ".num_cond"}, num_cond_branches, exp_cond);
        chk({name, ".num_uncond"}, num_uncond_branches, exp_uncond);
        chk({name, ".bp_correct"}, bp_correct, exp_correct);
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic [31:0] target, input logic is_cond,
                            input logic taken, input logic pred, input logic [7:0] ghr);
        ex_pc         = pc;
        ex_target     = target;
        ex_is_cond    = is_cond;
        ex_taken      = taken;
        ex_pred_taken = pred;
        ex_ghr        = ghr;
        ex_valid      = 1'b1;
    endtask

    task automatic model_ex(input logic is_cond, input logic taken, input logic pred);
        if (is_cond) begin
            exp_cond++;
            if (pred == taken) exp_correct++;
            exp_ghr = {exp_ghr[6:0], taken};
        end else begin
            exp_uncond++;
        end
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] target, input logic is_cond,
                           input logic taken, input logic pred, input logic [7:0] ghr);
        @(negedge clk);
        drive_ex(pc, target, is_cond, taken, pred, ghr);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        model_ex(is_cond, taken, pred);
    endtask

    initial begin
        pred_tbl[0] = '{32'h0000_0100, 1'b0, 32'h0000_0104};
        pred_tbl[1] = '{32'h0000_1100, 1'b1, 32'h0000_0900};
        pred_tbl[2] = '{32'h0000_0200, 1'b0, 32'h0000_0204};
        pred_tbl[3] = '{32'h0000_0104, 1'b0, 32'h0000_0108};
        pred_tbl[4] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000};

        ctr_tbl[0] = '{1'b1, 2'd2};
        ctr_tbl[1] = '{1'b1, 2'd3};
        ctr_tbl[2] = '{1'b1, 2'd3};
        ctr_tbl[3] = '{1'b1, 2'd3};
        ctr_tbl[4] = '{1'b1, 2'd3};
        ctr_tbl[5] = '{1'b0, 2'd2};
        ctr_tbl[6] = '{1'b0, 2'd1};
        ctr_tbl[7] = '{1'b0, 2'd0};
        ctr_tbl[8] = '{1'b0, 2'd0};
        ctr_tbl[9] = '{1'b0, 2'd0};

        rst           = 1'b1;
        if_pc         = 32'h0000_0100;
        ex_valid      = 1'b0;
        ex_pc         = '0;
        ex_target     = '0;
        ex_is_cond    = 1'b0;
        ex_taken      = 1'b0;
        ex_pred_taken = 1'b0;
        ex_ghr        = '0;
        exp_ghr       = '0;
        exp_cond      = '0;
        exp_uncond    = '0;
        exp_correct   = '0;

        #1;
        check_pred("reset", 32'h0000_0100, 1'b0, 32'h0000_0104);
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Conditional taken: counter 0x40 -> 2, but the next fetch indexes 0x41
        resolve(32'h0000_0100, 32'h0000_0080, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("s2.bht40", {30'd0, dut.bht_q[8'h40]}, 32'd2);
        check_state("s2");
        check_pred("s2.miss_dir", 32'h0000_0100, 1'b0, 32'h0000_0104);
        resolve(32'h0000_0100, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 8'h03);
        chk("s2.bht43", {30'd0, dut.bht_q[8'h43]}, 32'd2);
        check_state("s2b");
        check_pred("s2.hit", 32'h0000_0100, 1'b1, 32'h0000_0080);

        resolve(32'h0000_0200, 32'h0000_0400, 1'b0, 1'b1, 1'b0, 8'h00);
        check_state("s3");
        check_pred("s3.jal", 32'h0000_0200, 1'b1, 32'h0000_0400);

        // Aliasing on BTB slot 0, plus a not-taken conditional that must not allocate
        resolve(32'h0000_0100, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 8'h00);
        check_pred("s5.first", 32'h0000_0100, 1'b1, 32'h0000_0080);
        resolve(32'h0000_1100, 32'h0000_0900, 1'b0, 1'b1, 1'b0, 8'h00);
        resolve(32'h0000_0104, 32'h0000_0700, 1'b1, 1'b0, 1'b0, exp_ghr);
        for (int i = 0; i < 5; i++) begin
            check_pred($sformatf("tbl%0d", i), pred_tbl[i].pc, pred_tbl[i].taken, pred_tbl[i].target);
        end
        check_state("s5");

        // Same-cycle read of a slot being written sees the old contents
        @(negedge clk);
        if_pc = 32'h0000_0108;
        drive_ex(32'h0000_0108, 32'h0000_0600, 1'b0, 1'b1, 1'b0, 8'h00);
        #1;
        chk("bypass.pre_taken", {31'd0, pred_taken}, 32'd0);
        chk("bypass.pre_target", pred_target, 32'h0000_010C);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        model_ex(1'b0, 1'b1, 1'b0);
        check_pred("bypass.post", 32'h0000_0108, 1'b1, 32'h0000_0600);

        @(negedge clk);
        drive_ex(32'h0000_0300, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 8'h0F);
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        check_state("idle");
        chk("idle.bhtCF", {30'd0, dut.bht_q[8'hCF]}, 32'd1);
        check_pred("idle.btb", 32'h0000_0300, 1'b0, 32'h0000_0304);

        for (int i = 0; i < 10; i++) begin
            resolve(32'h0000_0300, 32'h0000_0080, 1'b1, ctr_tbl[i].taken, 1'b1, 8'h0F);
            chk($sformatf("s4.ctr%0d", i), {30'd0, dut.bht_q[8'hCF]}, {30'd0, ctr_tbl[i].ctr});
        end
        check_state("s4");

        // Reset lands mid-cycle while an update is being presented
        @(negedge clk);
        if_pc = 32'h0000_1100;
        drive_ex(32'h0000_0100, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 8'h00);
        #2;
        rst = 1'b1;
        exp_ghr     = '0;
        exp_cond    = '0;
        exp_uncond  = '0;
        exp_correct = '0;
        check_pred("s6.async", 32'h0000_1100, 1'b0, 32'h0000_1104);
        check_state("s6.async");
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        chk("s6.bht40", {30'd0, dut.bht_q[8'h40]}, 32'd1);
        check_state("s6.edge");
        @(negedge clk);
        rst = 1'b0;
        check_pred("s6.after", 32'h0000_0200, 1'b0, 32'h0000_0204);
        check_state("s6.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
